// File: rtl/ecc_mac_pkg.sv
// ecc_mac_pkg: shared types, defaults and the round-robin pick function for
// the ECC/MAC tag scheduler.
//   state_t  : scheduler FSM encoding (S_IDLE, S_RUN, S_RESP)
//   DEF_N    : default requester count
//   DEF_W    : default operand width / serial run length
//   MAX_N    : largest requester count rr_pick supports
//   rr_pick  : first set bit of req searching upward from (ptr+1) mod n, wrapping
package ecc_mac_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 32;
  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Returns 0 when req is empty; callers qualify the result with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [2:0]       ptr,
                                         input int               n);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        cand = 3'((int'(ptr) + k) % n);
        if (!found && req[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gf2_tag_engine.sv
// gf2_tag_engine: bit-serial GF(2) tag datapath. One operand bit per cycle,
// LSB first: acc_next = acc ^ (x[i] & r[i]); y[i] = acc_next.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   i_start    : load i_x / i_r, clear y and acc, begin a W-cycle run
//   i_x, i_r   : operands, sampled only on i_start
//   o_y        : result; final once the run has finished
//   o_done     : high during the last run cycle (bit W-1 being processed)
module gf2_tag_engine #(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_r,
  output logic [W-1:0] o_y,
  output logic         o_done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  logic [W-1:0]  r_x;
  logic [W-1:0]  r_r;
  logic [W-1:0]  r_y;
  logic          r_acc;
  logic [CW-1:0] r_i;
  logic          r_run;
  logic          w_acc_next;

  // Operands shift right so bit i is always at position 0; the result shifts
  // in from the top so that after W steps bit i lands at position i.
  assign w_acc_next = r_acc ^ (r_x[0] & r_r[0]);
  assign o_done     = r_run && (r_i == LAST_IDX);
  assign o_y        = r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x   <= '0;
      r_r   <= '0;
      r_y   <= '0;
      r_acc <= 1'b0;
      r_i   <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_x   <= i_x;
      r_r   <= i_r;
      r_y   <= '0;
      r_acc <= 1'b0;
      r_i   <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_x   <= r_x >> 1;
      r_r   <= r_r >> 1;
      r_acc <= w_acc_next;
      r_y   <= {w_acc_next, r_y[W-1:1]};
      r_i   <= r_i + CW'(1);
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ecc_mac_scheduler.sv
// ecc_mac_scheduler: shares one bit-serial GF(2) tag engine between N
// requesters. Round-robin grant, operand capture, W-cycle serial run, result
// returned with the owning requester id. Exactly one job in flight.
// Optional feature macro: SCHED_PERF_EN adds grant_cnt / stall_cnt counters.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   req_valid[N] : per-requester request, operands held stable until granted
//   req_ready[N] : one-hot capture strobe, combinational, only in IDLE
//   req_x/req_r  : N*W packed operands, requester k at [k*W +: W]
//   rsp_valid    : result held until rsp_ready
//   rsp_ready    : consumer accepts result
//   rsp_id       : requester that owns rsp_y
//   rsp_y        : result tag
//   busy         : high in RUN or RESP
//   grant_cnt    : (SCHED_PERF_EN) 16-bit saturating grant count per requester
//   stall_cnt    : (SCHED_PERF_EN) saturating count of RESP cycles with rsp_ready=0
//   o_dbg_state  : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source keeps its payload stable until that edge; ready
// never waits for a future edge. Requesters may withdraw valid before grant.
module ecc_mac_scheduler
  import ecc_mac_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*W-1:0]  req_x,
  input  logic [N*W-1:0]  req_r,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_y,
  output logic            busy,
`ifdef SCHED_PERF_EN
  output logic [N*16-1:0] grant_cnt,
  output logic [15:0]     stall_cnt,
`endif
  output state_t          o_dbg_state
);

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [IW-1:0]   w_gidx;
  logic [W-1:0]    w_sel_x;
  logic [W-1:0]    w_sel_r;
  logic            w_start;
  logic            w_done;
  logic [W-1:0]    w_y;

  assign w_gidx  = IW'(rr_pick(MAX_N'(req_valid), 3'(r_ptr), N));
  assign w_sel_x = req_x[w_gidx*W +: W];
  assign w_sel_r = req_r[w_gidx*W +: W];

  // Reset gates the grant so no requester sees a capture that never happens.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready    = N'(1) << w_gidx;
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_done) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(N - 1);
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_ptr <= w_gidx;
        r_id  <= w_gidx;
      end
    end
  end

  gf2_tag_engine #(.W(W)) u_engine (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_x     (w_sel_x),
    .i_r     (w_sel_r),
    .o_y     (w_y),
    .o_done  (w_done)
  );

  // The engine is idle outside RUN, so its result register is the response
  // register: stable through RESP and cleared at every capture.
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_id;
  assign rsp_y       = w_y;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

`ifdef SCHED_PERF_EN
  logic [N*16-1:0] r_grant_cnt;
  logic [15:0]     r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_ready[k] && (r_grant_cnt[k*16 +: 16] != 16'hFFFF)) begin
          r_grant_cnt[k*16 +: 16] <= r_grant_cnt[k*16 +: 16] + 16'd1;
        end
      end
      if ((r_state == S_RESP) && !rsp_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
